// File: rtl/exec_pkg.sv
// Shared definitions for the execute-buffer read side: entry class codes,
// default entry width and the lane slot state encoding.
// No ports; imported by execute_issue_reader and issue_slot.
package exec_pkg;

  localparam int DATA_W_DEFAULT = 128;

  // Entry class lives in the two MSBs of each buffer entry.
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_LSU = 2'b10;
  localparam logic [1:0] CLS_ILL = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/issue_slot.sv
// Single-entry lane output register with valid/ready handshake, load and flush.
// Ports: clk_i/rst_ni, flush_i (clear), load_i/data_i (fill), ready_i (lane
// accepts), valid_o/data_o (slot contents). Data holds while empty or stalled.
module issue_slot
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Load is only asserted by the parent when the slot is free, so in FULL a
  // load always coincides with the lane taking the current entry.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = SLOT_EMPTY;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
          end
        end
        SLOT_FULL: begin
          if (load_i) begin
            data_d = data_i;
          end else if (ready_i) begin
            state_d = SLOT_EMPTY;
          end
        end
        default: state_d = SLOT_EMPTY;
      endcase
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/execute_issue_reader.sv
// In-order drain of the execute buffer into two lane slots (lane0 MUL/ALU,
// lane1 LSU/ALU); illegal-class entries are popped, dropped and flagged.
// Ports: clk/rst_n, flush, buf_* (FWFT head + pop), lane0_*/lane1_* slots,
// illegal_drop pulse. Optional ISSUE_STATS_EN adds stat_issued/stall/drop.
module execute_issue_reader
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
`ifdef ISSUE_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_data,
  output logic              buf_read,
  output logic              lane0_valid,
  input  logic              lane0_ready,
  output logic [DATA_W-1:0] lane0_data,
  output logic              lane1_valid,
  input  logic              lane1_ready,
  output logic [DATA_W-1:0] lane1_data,
  output logic              illegal_drop
`ifdef ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_issued,
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_drop
`endif
);

  logic [1:0] cls;
  logic       free0, free1;
  logic       load0, load1, pop_ill;
  logic       drop_q;

  assign cls   = buf_data[DATA_W-1 -: 2];
  // A full slot whose lane takes the entry this cycle can be refilled now.
  assign free0 = !lane0_valid || lane0_ready;
  assign free1 = !lane1_valid || lane1_ready;

  // Only the head is considered; if its target is busy nothing younger moves.
  always_comb begin
    buf_read = 1'b0;
    load0    = 1'b0;
    load1    = 1'b0;
    pop_ill  = 1'b0;
    if (!flush && !buf_empty) begin
      case (cls)
        CLS_ALU: begin
          load0    = free0;
          load1    = !free0 && free1;
          buf_read = free0 || free1;
        end
        CLS_MUL: begin
          load0    = free0;
          buf_read = free0;
        end
        CLS_LSU: begin
          load1    = free1;
          buf_read = free1;
        end
        default: begin
          pop_ill  = 1'b1;
          buf_read = 1'b1;
        end
      endcase
    end
  end

  issue_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .load_i  (load0),
    .data_i  (buf_data),
    .ready_i (lane0_ready),
    .valid_o (lane0_valid),
    .data_o  (lane0_data)
  );

  issue_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .load_i  (load1),
    .data_i  (buf_data),
    .ready_i (lane1_ready),
    .valid_o (lane1_valid),
    .data_o  (lane1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= pop_ill;
  end

  assign illegal_drop = drop_q;

`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] issued_q, stall_q, sdrop_q;
  logic             inc_issued, inc_stall;

  assign inc_issued = buf_read && !pop_ill;
  assign inc_stall  = !buf_empty && !buf_read && !flush;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
      sdrop_q  <= '0;
    end else begin
      if (inc_issued && !(&issued_q)) issued_q <= issued_q + 1'b1;
      if (inc_stall  && !(&stall_q))  stall_q  <= stall_q + 1'b1;
      if (pop_ill    && !(&sdrop_q))  sdrop_q  <= sdrop_q + 1'b1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
  assign stat_drop   = sdrop_q;
`endif

endmodule

// File: tb/tb_execute_issue_reader.sv
module tb_execute_issue_reader;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          buf_empty = 1'b1;
  logic [DW-1:0] buf_data = '0;
  logic          buf_read;
  logic          lane0_valid, lane1_valid;
  logic          lane0_ready = 1'b0, lane1_ready = 1'b0;
  logic [DW-1:0] lane0_data, lane1_data;
  logic          illegal_drop;
`ifdef ISSUE_STATS_EN
  logic [15:0]   stat_issued, stat_stall, stat_drop;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_issue_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .buf_empty    (buf_empty),
    .buf_data     (buf_data),
    .buf_read     (buf_read),
    .lane0_valid  (lane0_valid),
    .lane0_ready  (lane0_ready),
    .lane0_data   (lane0_data),
    .lane1_valid  (lane1_valid),
    .lane1_ready  (lane1_ready),
    .lane1_data   (lane1_data),
    .illegal_drop (illegal_drop)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_stall   (stat_stall),
    .stat_drop    (stat_drop)
`endif
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] c, input int v);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1 -: 2] = c;
    r[31:0] = v;
    return r;
  endfunction

  // Present a head entry at the negedge, then let the comb pop settle.
  task automatic present(input logic [1:0] c, input int v);
    @(negedge clk);
    buf_empty = 1'b0;
    buf_data  = mk(c, v);
    #1;
  endtask

  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    buf_empty = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({lane0_valid, lane1_valid, illegal_drop, buf_read} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0000", {lane0_valid, lane1_valid, illegal_drop, buf_read});
    end
    n_checks++;
    if (lane0_data !== '0 || lane1_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0", lane0_data, lane1_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lane0_ready = 1'b1;
    lane1_ready = 1'b1;
    #1;
    n_checks++;
    if (buf_read !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_no_read got %b want 0", buf_read);
    end
  endtask

  task automatic test_alu_basic();
    present(2'b00, 100);
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_pop got %b want 1", buf_read);
    end
    edge_then_idle();
    lane0_ready = 1'b0;
    n_checks++;
    if (lane0_valid !== 1'b1 || lane0_data[31:0] !== 32'd100 || lane1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_lane0 got v0=%b d=%0d v1=%b want 1 100 0", lane0_valid, lane0_data[31:0], lane1_valid);
    end
  endtask

  task automatic test_alu_to_lane1();
    present(2'b00, 200);
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_lane1_pop got %b want 1", buf_read);
    end
    edge_then_idle();
    n_checks++;
    if (lane1_valid !== 1'b1 || lane1_data[31:0] !== 32'd200) begin
      n_fail++;
      $display("FAIL alu_lane1 got v1=%b d=%0d want 1 200", lane1_valid, lane1_data[31:0]);
    end
    n_checks++;
    if (lane0_valid !== 1'b1 || lane0_data[31:0] !== 32'd100) begin
      n_fail++;
      $display("FAIL lane0_hold got v0=%b d=%0d want 1 100", lane0_valid, lane0_data[31:0]);
    end
  endtask

  task automatic test_mul_stall();
    // lane1 drains during the stall; a free lane1 must not let MUL bypass.
    present(2'b01, 300);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (buf_read !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_stall cycle %0d got %b want 0", i, buf_read);
      end
      @(negedge clk);
      #1;
    end
    lane0_ready = 1'b1;
    #1;
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_release got %b want 1", buf_read);
    end
    edge_then_idle();
    lane0_ready = 1'b0;
    n_checks++;
    if (lane0_valid !== 1'b1 || lane0_data[31:0] !== 32'd300 || lane1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_load got v0=%b d=%0d v1=%b want 1 300 0", lane0_valid, lane0_data[31:0], lane1_valid);
    end
  endtask

  task automatic test_illegal();
    present(2'b11, 7);
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_pop got %b want 1", buf_read);
    end
    edge_then_idle();
    n_checks++;
    if (illegal_drop !== 1'b1 || lane1_valid !== 1'b0 || lane0_data[31:0] !== 32'd300) begin
      n_fail++;
      $display("FAIL ill_drop got drop=%b v1=%b d0=%0d want 1 0 300", illegal_drop, lane1_valid, lane0_data[31:0]);
    end
`ifdef ISSUE_STATS_EN
    n_checks++;
    if (stat_drop !== 16'd1) begin
      n_fail++;
      $display("FAIL stat_drop got %0d want 1", stat_drop);
    end
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_pulse_len got %b want 0", illegal_drop);
    end
  endtask

  task automatic test_flush();
    lane1_ready = 1'b0;
    present(2'b10, 400);
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL lsu_pop got %b want 1", buf_read);
    end
    edge_then_idle();
    present(2'b00, 500);
    flush = 1'b1;
    #1;
    n_checks++;
    if (buf_read !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_read got %b want 0", buf_read);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (lane0_valid !== 1'b0 || lane1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear got v0=%b v1=%b want 0 0", lane0_valid, lane1_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (buf_read !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_resume got %b want 1", buf_read);
    end
    edge_then_idle();
    n_checks++;
    if (lane0_valid !== 1'b1 || lane0_data[31:0] !== 32'd500) begin
      n_fail++;
      $display("FAIL flush_reload got v0=%b d=%0d want 1 500", lane0_valid, lane0_data[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    lane0_ready = 1'b1;
    lane1_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      buf_empty = 1'b0;
      buf_data  = mk(2'b00, i * 11);
      @(posedge clk);
      #1;
      n_checks++;
      if (lane0_valid !== 1'b1 || lane0_data[31:0] !== 32'(i * 11) || lane1_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d got v0=%b d=%0d v1=%b want 1 %0d 0", i, lane0_valid, lane0_data[31:0], lane1_valid, i * 11);
      end
    end
    buf_empty = 1'b1;
  endtask

  task automatic test_async_reset();
    lane0_ready = 1'b0;
    lane1_ready = 1'b0;
    present(2'b00, 600);
    edge_then_idle();
    present(2'b00, 700);
    edge_then_idle();
    n_checks++;
    if (lane0_valid !== 1'b1 || lane1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_full got v0=%b v1=%b want 1 1", lane0_valid, lane1_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (lane0_valid !== 1'b0 || lane1_valid !== 1'b0 || lane0_data !== '0 || lane1_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset got v0=%b v1=%b want 0 0 with zero data", lane0_valid, lane1_valid);
    end
`ifdef ISSUE_STATS_EN
    n_checks++;
    if (stat_issued !== 16'd0 || stat_stall !== 16'd0 || stat_drop !== 16'd0) begin
      n_fail++;
      $display("FAIL stat_reset got %0d %0d %0d want 0 0 0", stat_issued, stat_stall, stat_drop);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_to_lane1();
    test_mul_stall();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
